// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the two cache requesters, the shared memory port and the arbiter.
// The arbiter uses the slave view; the environment (requesters + memory) uses the master view.
interface mem_port_arbiter_if #(
    parameter int WORD_SIZE        = 32,
    parameter int BLOCK_DATA_WIDTH = 512
);
    logic                        c0_req_enable;
    logic                        c0_req_rw;
    logic [WORD_SIZE-1:0]        c0_req_addr;
    logic [BLOCK_DATA_WIDTH-1:0] c0_req_dataout;
    logic [BLOCK_DATA_WIDTH-1:0] c0_res_datain;
    logic                        c0_res_ready;

    logic                        c1_req_enable;
    logic                        c1_req_rw;
    logic [WORD_SIZE-1:0]        c1_req_addr;
    logic [BLOCK_DATA_WIDTH-1:0] c1_req_dataout;
    logic [BLOCK_DATA_WIDTH-1:0] c1_res_datain;
    logic                        c1_res_ready;

    logic                        mem_req_enable;
    logic                        mem_req_rw;
    logic [WORD_SIZE-1:0]        mem_req_addr;
    logic [BLOCK_DATA_WIDTH-1:0] mem_req_dataout;
    logic [BLOCK_DATA_WIDTH-1:0] mem_req_datain;
    logic                        mem_req_ready;

    logic [1:0]                  grant;
    logic                        timeout_err;

    modport slave (
        input  c0_req_enable, c0_req_rw, c0_req_addr, c0_req_dataout,
        output c0_res_datain, c0_res_ready,
        input  c1_req_enable, c1_req_rw, c1_req_addr, c1_req_dataout,
        output c1_res_datain, c1_res_ready,
        output mem_req_enable, mem_req_rw, mem_req_addr, mem_req_dataout,
        input  mem_req_datain, mem_req_ready,
        output grant, timeout_err
    );

    modport master (
        output c0_req_enable, c0_req_rw, c0_req_addr, c0_req_dataout,
        input  c0_res_datain, c0_res_ready,
        output c1_req_enable, c1_req_rw, c1_req_addr, c1_req_dataout,
        input  c1_res_datain, c1_res_ready,
        input  mem_req_enable, mem_req_rw, mem_req_addr, mem_req_dataout,
        output mem_req_datain, mem_req_ready,
        input  grant, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one block-memory port between two cache controllers,
// with a sticky memory-latency watchdog. All outputs are registered.
module mem_port_arbiter #(
    parameter int WORD_SIZE        = 32,
    parameter int BLOCK_DATA_WIDTH = 512,
    parameter int TIMEOUT_BITS     = 8
) (
    input logic           clk,
    input logic           rst_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // Fire on the cycle the count would reach all-ones: 2^N-1 cycles spent in ISSUE.
    localparam logic [TIMEOUT_BITS-1:0] WDOG_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

    state_t                      state_q,  state_d;
    logic                        ptr_q,    ptr_d;
    logic                        owner_q,  owner_d;
    logic [TIMEOUT_BITS-1:0]     wdog_q,   wdog_d;
    logic [1:0]                  grant_q,  grant_d;
    logic                        en_q,     en_d;
    logic                        rw_q,     rw_d;
    logic [WORD_SIZE-1:0]        addr_q,   addr_d;
    logic [BLOCK_DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic [BLOCK_DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [BLOCK_DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                        rdy0_q,   rdy0_d;
    logic                        rdy1_q,   rdy1_d;
    logic                        terr_q,   terr_d;
    logic                        win;
    logic                        finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            wdog_q   <= '0;
            grant_q  <= '0;
            en_q     <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            rdy0_q   <= 1'b0;
            rdy1_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            wdog_q   <= wdog_d;
            grant_q  <= grant_d;
            en_q     <= en_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            rdy0_q   <= rdy0_d;
            rdy1_q   <= rdy1_d;
            terr_q   <= terr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        wdog_d   = wdog_q;
        grant_d  = grant_q;
        en_d     = en_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        rdy0_d   = 1'b0;
        rdy1_d   = 1'b0;
        terr_d   = terr_q;
        win      = 1'b0;
        finish   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.c0_req_enable || bus.c1_req_enable) begin
                    win     = (bus.c0_req_enable && bus.c1_req_enable) ? ptr_q : bus.c1_req_enable;
                    owner_d = win;
                    ptr_d   = ~ptr_q;
                    grant_d = win ? 2'b10 : 2'b01;
                    en_d    = 1'b1;
                    rw_d    = win ? bus.c1_req_rw      : bus.c0_req_rw;
                    addr_d  = win ? bus.c1_req_addr    : bus.c0_req_addr;
                    wdata_d = win ? bus.c1_req_dataout : bus.c0_req_dataout;
                    wdog_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_req_ready) begin
                    finish = 1'b1;
                    if (!rw_q) begin
                        if (owner_q) rdata1_d = bus.mem_req_datain;
                        else         rdata0_d = bus.mem_req_datain;
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    finish = 1'b1;
                    terr_d = 1'b1;
                    if (!rw_q) begin
                        if (owner_q) rdata1_d = '0;
                        else         rdata0_d = '0;
                    end
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
                if (finish) begin
                    en_d    = 1'b0;
                    wdog_d  = '0;
                    rdy0_d  = ~owner_q;
                    rdy1_d  = owner_q;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.c0_res_datain   = rdata0_q;
    assign bus.c0_res_ready    = rdy0_q;
    assign bus.c1_res_datain   = rdata1_q;
    assign bus.c1_res_ready    = rdy1_q;
    assign bus.mem_req_enable  = en_q;
    assign bus.mem_req_rw      = rw_q;
    assign bus.mem_req_addr    = addr_q;
    assign bus.mem_req_dataout = wdata_q;
    assign bus.grant           = grant_q;
    assign bus.timeout_err     = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + randomized bench for mem_port_arbiter against a transaction-level model
// (pending flags, round-robin toggle, per-requester expected read block, sticky timeout).
module tb_mem_port_arbiter;

    localparam int WS = 32;
    localparam int BW = 512;
    typedef logic [BW-1:0] blk_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.WORD_SIZE(WS), .BLOCK_DATA_WIDTH(BW)) bus ();

    mem_port_arbiter #(.WORD_SIZE(WS), .BLOCK_DATA_WIDTH(BW), .TIMEOUT_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    bit            pend   [2];
    bit            rw     [2];
    logic [WS-1:0] addr   [2];
    blk_t          wdat   [2];
    blk_t          exp_rd [2];
    bit            rr;
    bit            exp_terr;

    task automatic chk(input string tag, input blk_t obs, input blk_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic drive_reqs();
        bus.c0_req_enable  = pend[0];
        bus.c0_req_rw      = rw[0];
        bus.c0_req_addr    = addr[0];
        bus.c0_req_dataout = wdat[0];
        bus.c1_req_enable  = pend[1];
        bus.c1_req_rw      = rw[1];
        bus.c1_req_addr    = addr[1];
        bus.c1_req_dataout = wdat[1];
    endtask

    task automatic new_req(input int r, input bit w, input logic [WS-1:0] a, input blk_t d);
        pend[r] = 1'b1;
        rw[r]   = w;
        addr[r] = a;
        wdat[r] = d;
    endtask

    task automatic model_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        rr = 1'b0;
        exp_terr = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, blk_t'({bus.mem_req_enable, bus.mem_req_rw, bus.c0_res_ready,
                                   bus.c1_res_ready, bus.grant, bus.timeout_err}), '0);
        chk({tag, "_addr"}, blk_t'(bus.mem_req_addr), '0);
        chk({tag, "_wdata"}, bus.mem_req_dataout, '0);
        chk({tag, "_c0_data"}, bus.c0_res_datain, '0);
        chk({tag, "_c1_data"}, bus.c1_res_datain, '0);
    endtask

    // Called at a negedge with requests already driven; serves exactly one grant.
    task automatic serve_one(input bit to_mode, input int lat, output int winner, output int wait_cycles);
        int   n;
        blk_t rd;
        n = 0;
        while (bus.mem_req_enable !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        wait_cycles = n;
        if (bus.mem_req_enable !== 1'b1) begin
            chk("grant_wait", blk_t'(bus.mem_req_enable), blk_t'(1'b1));
            winner = -1;
            return;
        end
        winner = (pend[0] && pend[1]) ? int'(rr) : (pend[1] ? 1 : 0);
        rr = ~rr;
        chk("grant", blk_t'(bus.grant), blk_t'(winner == 1 ? 2'b10 : 2'b01));
        chk("mem_addr", blk_t'(bus.mem_req_addr), blk_t'(addr[winner]));
        chk("mem_rw", blk_t'(bus.mem_req_rw), blk_t'(rw[winner]));
        if (rw[winner]) chk("mem_wdata", bus.mem_req_dataout, wdat[winner]);
        // Changing the owner's request fields after grant must not disturb the memory side.
        if (winner == 1) begin bus.c1_req_addr = $urandom; bus.c1_req_dataout = rand_blk(); end
        else             begin bus.c0_req_addr = $urandom; bus.c0_req_dataout = rand_blk(); end

        if (!to_mode) begin
            for (int i = 1; i < lat; i++) begin
                @(negedge clk);
                chk("issue_hold", blk_t'({bus.mem_req_enable, bus.c0_res_ready, bus.c1_res_ready}), blk_t'(3'b100));
                chk("addr_stable", blk_t'(bus.mem_req_addr), blk_t'(addr[winner]));
            end
            rd = rand_blk();
            bus.mem_req_datain = rd;
            bus.mem_req_ready  = 1'b1;
            @(negedge clk);
            bus.mem_req_ready  = 1'b0;
            bus.mem_req_datain = rand_blk();
            if (!rw[winner]) exp_rd[winner] = rd;
        end else begin
            n = 1;
            while (n < 300) begin
                @(negedge clk);
                if (bus.mem_req_enable !== 1'b1) break;
                n++;
            end
            chk("timeout_len", blk_t'(n), blk_t'(255));
            exp_terr = 1'b1;
            if (!rw[winner]) exp_rd[winner] = '0;
        end

        chk("respond_ready", blk_t'({bus.c1_res_ready, bus.c0_res_ready}),
            blk_t'(winner == 1 ? 2'b10 : 2'b01));
        chk("respond_en", blk_t'(bus.mem_req_enable), '0);
        chk("respond_grant", blk_t'(bus.grant), blk_t'(winner == 1 ? 2'b10 : 2'b01));
        chk("c0_datain", bus.c0_res_datain, exp_rd[0]);
        chk("c1_datain", bus.c1_res_datain, exp_rd[1]);
        chk("timeout_err", blk_t'(bus.timeout_err), blk_t'(exp_terr));
        pend[winner] = 1'b0;
        drive_reqs();
        @(negedge clk);
        chk("idle_gap", blk_t'({bus.grant, bus.mem_req_enable, bus.c0_res_ready, bus.c1_res_ready}), '0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   w, n, prev;
        blk_t pat;
        blk_t cafe;

        bus.mem_req_ready  = 1'b0;
        bus.mem_req_datain = '0;
        model_reset();
        for (int r = 0; r < 2; r++) begin rw[r] = 1'b0; addr[r] = '0; wdat[r] = '0; end

        // Both requesters enabled while still in reset.
        new_req(0, 1'b0, $urandom, rand_blk());
        new_req(1, 1'b0, $urandom, rand_blk());
        drive_reqs();
        #23;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int round = 0; round < 2; round++) begin
            serve_one(1'b0, 2, w, n);
            chk("simul_first", blk_t'(w), blk_t'(0));
            serve_one(1'b0, 1, w, n);
            chk("simul_second", blk_t'(w), blk_t'(1));
            if (round == 0) begin
                new_req(0, 1'b0, $urandom, rand_blk());
                new_req(1, 1'b0, $urandom, rand_blk());
                drive_reqs();
            end
        end

        // A ready pulse outside ISSUE must be ignored.
        bus.mem_req_ready = 1'b1;
        bus.mem_req_datain = rand_blk();
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        chk("stray_ready", blk_t'({bus.grant, bus.mem_req_enable, bus.c0_res_ready, bus.c1_res_ready}), '0);
        chk("stray_c0_data", bus.c0_res_datain, exp_rd[0]);

        // Single read from c0 with a word-indexed pattern.
        for (int i = 0; i < BW / 32; i++) pat[i*32 +: 32] = 32'hDEADBEEF + 32'(i);
        new_req(0, 1'b0, 32'h0000_0AB0, rand_blk());
        drive_reqs();
        @(negedge clk);
        chk("issue_latency", blk_t'(bus.mem_req_enable), blk_t'(1'b1));
        w = 0;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            chk("single_hold", blk_t'({bus.mem_req_enable, bus.c1_res_ready}), blk_t'(2'b10));
        end
        bus.mem_req_datain = pat;
        bus.mem_req_ready  = 1'b1;
        @(negedge clk);
        bus.mem_req_ready  = 1'b0;
        rr = ~rr;
        exp_rd[0] = pat;
        chk("single_ready", blk_t'({bus.c1_res_ready, bus.c0_res_ready}), blk_t'(2'b01));
        chk("single_data", bus.c0_res_datain, pat);
        chk("single_addr", blk_t'(bus.mem_req_addr), blk_t'(32'h0000_0AB0));
        pend[0] = 1'b0;
        drive_reqs();
        @(negedge clk);
        chk("single_pulse", blk_t'({bus.c1_res_ready, bus.c0_res_ready, bus.grant}), '0);

        // Sustained contention with random read/write mix and memory latency.
        new_req(0, 1'($urandom), $urandom, rand_blk());
        new_req(1, 1'($urandom), $urandom, rand_blk());
        drive_reqs();
        prev = -1;
        for (int k = 0; k < 8; k++) begin
            serve_one(1'b0, 1 + int'($urandom_range(0, 4)), w, n);
            if (prev >= 0) chk("alternate", blk_t'(w == prev), '0);
            prev = w;
            if (k < 6 && w >= 0) begin
                new_req(w, 1'($urandom), $urandom, rand_blk());
                drive_reqs();
            end
        end

        // Block write from c1.
        cafe = {16{32'hCAFEBABE}};
        new_req(1, 1'b1, 32'h0000_0DE0, cafe);
        drive_reqs();
        serve_one(1'b0, 2, w, n);
        chk("write_owner", blk_t'(w), blk_t'(1));

        // Watchdog: memory never answers a c0 read.
        new_req(0, 1'b0, $urandom, rand_blk());
        drive_reqs();
        serve_one(1'b1, 0, w, n);
        new_req(1, 1'b0, $urandom, rand_blk());
        drive_reqs();
        serve_one(1'b0, 3, w, n);
        chk("after_timeout_owner", blk_t'(w), blk_t'(1));

        // Asynchronous reset in the middle of ISSUE.
        new_req(0, 1'b0, $urandom, rand_blk());
        drive_reqs();
        n = 0;
        while (bus.mem_req_enable !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("pre_reset_issue", blk_t'(bus.mem_req_enable), blk_t'(1'b1));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        drive_reqs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_no_ready", blk_t'({bus.c0_res_ready, bus.c1_res_ready, bus.mem_req_enable}), '0);
        end
        rst_n = 1'b1;
        new_req(1, 1'b0, $urandom, rand_blk());
        drive_reqs();
        serve_one(1'b0, 2, w, n);
        chk("post_reset_owner", blk_t'(w), blk_t'(1));
        chk("post_reset_latency", blk_t'(n), blk_t'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
